// File: rtl/axis_seq_checker_pkg.sv
// Shared types and helpers for the AXI4-Stream sequence checker and its
// TREADY oscillator.
package axis_seq_checker_pkg;

    typedef enum logic {IDLE, IN_PKT} chk_state_t;
    typedef enum logic {LOW, HIGH} rdy_state_t;

    // Saturating add of a 0..3 increment; callers zero-extend counters up to 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] val,
                                            input logic [1:0]  inc,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, val} + {31'b0, inc};
        if (sum > {1'b0, max}) return max;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// Free-running TREADY oscillator: READY_LOW cycles low, READY_HIGH cycles high,
// phase frozen and output low while enable is deasserted.
module axis_ready_gen
    import axis_seq_checker_pkg::*;
#(
    parameter int READY_LOW  = 2,
    parameter int READY_HIGH = 6
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic enable,
    output logic tready
);

    localparam int PMAX = (READY_LOW > READY_HIGH) ? READY_LOW : READY_HIGH;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] LOW_LAST  = PW'((READY_LOW > 0) ? READY_LOW - 1 : 0);
    localparam logic [PW-1:0] HIGH_LAST = PW'(READY_HIGH - 1);

    rdy_state_t    r_state, w_state_nxt;
    logic [PW-1:0] r_phase, w_phase_nxt;
    logic          r_tready, w_tready_nxt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= LOW;
            r_phase  <= '0;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_tready <= w_tready_nxt;
        end
    end

    // With READY_LOW=0 the LOW state is left on the first enabled cycle and never re-entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_tready_nxt = 1'b0;
        if (enable) begin
            case (r_state)
                LOW: begin
                    if (READY_LOW == 0 || r_phase == LOW_LAST) begin
                        w_state_nxt = HIGH;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + PW'(1);
                    end
                end
                HIGH: begin
                    if (r_phase == HIGH_LAST) begin
                        if (READY_LOW != 0) w_state_nxt = LOW;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + PW'(1);
                    end
                end
                default: ;
            endcase
            w_tready_nxt = (w_state_nxt == HIGH);
        end
    end

    assign tready = r_tready;

endmodule

// File: rtl/axis_seq_checker.sv
// AXI4-Stream sink checking per-beat sequence numbers and TLAST placement.
// Optional AXIS_SEQ_CHECKER_PAD_CHECK_EN: tdata bits outside the sequence field must be zero.
module axis_seq_checker
    import axis_seq_checker_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int SEQ_W      = 8,
    parameter int PKT_LEN    = 8,
    parameter int READY_LOW  = 2,
    parameter int READY_HIGH = 6,
    parameter int CNT_W      = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              enable,
    input  logic              clear,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              seq_err,
    output logic              last_err,
    output logic              pkt_done
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0]     LAST_IDX = BW'(PKT_LEN - 1);
    localparam logic [DATA_W-1:0] PAD_MASK = {DATA_W{1'b1}} >> SEQ_W;
    localparam logic [31:0]       CNT_MAX  = 32'({CNT_W{1'b1}});

    chk_state_t       r_state, w_state_nxt;
    logic [BW-1:0]    r_bidx, w_bidx_nxt, w_idx;
    logic             r_pkt_err, w_pkt_err_nxt;
    logic             w_hs, w_pad_err, w_at_last, w_close;
    logic             w_seq_err, w_last_err, w_done;
    logic [SEQ_W-1:0] w_seq_fld, w_exp_seq;
    logic [CNT_W-1:0] r_pkt_count, r_err_count;
    logic             r_seq_err, r_last_err, r_pkt_done;

    axis_ready_gen #(
        .READY_LOW  (READY_LOW),
        .READY_HIGH (READY_HIGH)
    ) u_ready_gen (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (enable),
        .tready  (s_axis_tready)
    );

    assign w_hs      = s_axis_tvalid && s_axis_tready;
    assign w_idx     = (r_state == IDLE) ? '0 : r_bidx;
    assign w_seq_fld = s_axis_tdata[DATA_W-1 -: SEQ_W];
    assign w_exp_seq = SEQ_W'(w_idx);
    assign w_at_last = (w_idx == LAST_IDX);

`ifdef AXIS_SEQ_CHECKER_PAD_CHECK_EN
    assign w_pad_err = |(s_axis_tdata & PAD_MASK);
`else
    logic w_unused_pad;
    assign w_unused_pad = |(s_axis_tdata & PAD_MASK);
    assign w_pad_err    = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_bidx    <= '0;
            r_pkt_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bidx    <= w_bidx_nxt;
            r_pkt_err <= w_pkt_err_nxt;
        end
    end

    // A close is either TLAST or the final beat index; a mismatch between the two is a TLAST error.
    always_comb begin
        w_state_nxt   = r_state;
        w_bidx_nxt    = r_bidx;
        w_pkt_err_nxt = r_pkt_err;
        w_seq_err     = 1'b0;
        w_last_err    = 1'b0;
        w_close       = 1'b0;
        w_done        = 1'b0;
        if (clear) begin
            w_state_nxt   = IDLE;
            w_bidx_nxt    = '0;
            w_pkt_err_nxt = 1'b0;
        end else if (w_hs) begin
            w_seq_err  = (w_seq_fld != w_exp_seq) || w_pad_err;
            w_last_err = (s_axis_tlast != w_at_last);
            w_close    = s_axis_tlast || w_at_last;
            if (w_close) begin
                w_state_nxt   = IDLE;
                w_bidx_nxt    = '0;
                w_pkt_err_nxt = 1'b0;
                w_done        = !(w_seq_err || w_last_err || r_pkt_err);
            end else begin
                w_state_nxt   = IN_PKT;
                w_bidx_nxt    = w_idx + BW'(1);
                w_pkt_err_nxt = r_pkt_err || w_seq_err;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            r_pkt_count <= '0;
            r_err_count <= '0;
            r_seq_err   <= 1'b0;
            r_last_err  <= 1'b0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_count <= CNT_W'(sat_add(32'(r_pkt_count), {1'b0, w_close}, CNT_MAX));
            r_err_count <= CNT_W'(sat_add(32'(r_err_count),
                                          {1'b0, w_seq_err} + {1'b0, w_last_err}, CNT_MAX));
            r_seq_err   <= w_seq_err;
            r_last_err  <= w_last_err;
            r_pkt_done  <= w_done;
        end
    end

    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;
    assign seq_err   = r_seq_err;
    assign last_err  = r_last_err;
    assign pkt_done  = r_pkt_done;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Self-checking bench for axis_seq_checker: directed packets from the test plan
// followed by randomized traffic, all compared against a packet-level model.
module tb_axis_seq_checker;

    localparam int DATA_W  = 64;
    localparam int SEQ_W   = 8;
    localparam int PKT_LEN = 8;
    localparam int RL      = 2;
    localparam int RH      = 6;
    localparam int CNT_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef AXIS_SEQ_CHECKER_PAD_CHECK_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tlast = 1'b0;
    logic              enable = 1'b1;
    logic              clear = 1'b0;
    logic [CNT_W-1:0]  pkt_count, err_count;
    logic              seq_err, last_err, pkt_done;

    axis_seq_checker #(
        .DATA_W(DATA_W), .SEQ_W(SEQ_W), .PKT_LEN(PKT_LEN),
        .READY_LOW(RL), .READY_HIGH(RH), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .enable(enable), .clear(clear),
        .pkt_count(pkt_count), .err_count(err_count),
        .seq_err(seq_err), .last_err(last_err), .pkt_done(pkt_done)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: cycles since reset release, beat position, sticky error, counters, pulses.
    int m_k = 0;
    int m_bidx = 0;
    bit m_perr = 1'b0;
    int m_pkts = 0;
    int m_errs = 0;
    bit e_seq = 1'b0, e_last = 1'b0, e_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Ready pattern: low for the first RL cycles after reset release, then RH high, repeating.
    function automatic bit m_rdy(input int k);
        return (k >= 1) && (((k + RH) % (RL + RH)) < RH);
    endfunction

    task automatic check_outputs();
        chk("tready", s_axis_tready, m_rdy(m_k));
        chk("pkt_count", pkt_count, m_pkts);
        chk("err_count", err_count, m_errs);
        chk("seq_err", seq_err, e_seq);
        chk("last_err", last_err, e_last);
        chk("pkt_done", pkt_done, e_done);
    endtask

    task automatic model_beat(input logic [DATA_W-1:0] d, input bit l);
        int fld;
        bit bad_seq, bad_last, final_pos, ends;
        fld       = int'(d[DATA_W-1 -: SEQ_W]);
        bad_seq   = (fld != (m_bidx % (1 << SEQ_W))) ||
                    (PAD_EN && (d[DATA_W-SEQ_W-1:0] != '0));
        final_pos = (m_bidx == PKT_LEN - 1);
        bad_last  = (l && !final_pos) || (!l && final_pos);
        ends      = l || final_pos;
        m_errs    = m_errs + int'(bad_seq) + int'(bad_last);
        if (m_errs > CMAX) m_errs = CMAX;
        e_seq  = bad_seq;
        e_last = bad_last;
        if (ends) begin
            m_pkts = (m_pkts < CMAX) ? m_pkts + 1 : CMAX;
            e_done = !(bad_seq || bad_last || m_perr);
            m_bidx = 0;
            m_perr = 1'b0;
        end else begin
            m_bidx++;
            m_perr = m_perr || bad_seq;
        end
    endtask

    task automatic tick(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit c,
                        output bit hs);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        clear         = c;
        hs     = v && m_rdy(m_k);
        e_seq  = 1'b0;
        e_last = 1'b0;
        e_done = 1'b0;
        if (c) begin
            m_pkts = 0;
            m_errs = 0;
            m_bidx = 0;
            m_perr = 1'b0;
        end else if (hs) begin
            model_beat(d, l);
        end
        @(posedge aclk);
        m_k++;
        @(negedge aclk);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = '0;
        clear = 1'b0;
        m_k = 0; m_bidx = 0; m_perr = 1'b0; m_pkts = 0; m_errs = 0;
        e_seq = 1'b0; e_last = 1'b0; e_done = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            @(negedge aclk);
            check_outputs();
        end
        aresetn = 1'b1;
    endtask

    task automatic send_raw(input logic [DATA_W-1:0] d, input bit l, input bit c);
        bit hs;
        int guard;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 32) begin
            tick(1'b1, d, l, c, hs);
            guard++;
        end
        if (!hs) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic send_beat(input int seq, input bit l, input bit c);
        logic [DATA_W-1:0] d;
        d = '0;
        d[DATA_W-1 -: SEQ_W] = SEQ_W'(seq);
        send_raw(d, l, c);
    endtask

    task automatic send_pkt(input int n, input int bad_idx, input int bad_val, input int last_idx);
        for (int i = 0; i < n; i++)
            send_beat((i == bad_idx) ? bad_val : i, i == last_idx, 1'b0);
    endtask

    initial begin
        bit hs;
        logic [DATA_W-1:0] d;
        int seq;
        bit v, l, c;

        do_reset(3);

        // Good packet
        send_pkt(8, -1, 0, 7);
        chk("good_pkt_done", pkt_done, 1);
        chk("good_pkt_count", pkt_count, 1);
        chk("good_err_count", err_count, 0);

        // Beat 3 carries sequence 5
        send_pkt(8, 3, 5, 7);
        chk("seq5_pkt_count", pkt_count, 2);
        chk("seq5_err_count", err_count, 1);

        // Early TLAST on beat 4, then a clean packet
        send_pkt(5, -1, 0, 4);
        chk("early_last_err", last_err, 1);
        send_pkt(8, -1, 0, 7);
        chk("after_early_done", pkt_done, 1);
        chk("after_early_err_count", err_count, 2);

        // Wrong sequence and TLAST together on beat 2
        send_pkt(3, 2, 9, 2);
        chk("both_seq_err", seq_err, 1);
        chk("both_last_err", last_err, 1);
        chk("both_err_count", err_count, 4);

        // Five bad beats drive the error counter into saturation
        for (int i = 0; i < 5; i++) send_beat(8'hFF, 1'b0, 1'b0);
        chk("sat_err_count", err_count, CMAX);

        // Clear during a handshake: counters drop and the beat is not checked
        send_beat(8'hAA, 1'b1, 1'b1);
        chk("clear_err_count", err_count, 0);
        chk("clear_pkt_count", pkt_count, 0);
        chk("clear_seq_err", seq_err, 0);

        // Nonzero pad bit on beat 0
        d = 64'h0000_0000_0000_0001;
        send_raw(d, 1'b0, 1'b0);
        chk("pad_seq_err", seq_err, PAD_EN);
        for (int i = 1; i < 8; i++) send_beat(i, i == 7, 1'b0);

        // Reset mid-packet: next packet starts again from sequence 0
        send_pkt(3, -1, 0, -1);
        do_reset(2);
        send_pkt(8, -1, 0, 7);
        chk("post_reset_done", pkt_done, 1);
        chk("post_reset_pkt_count", pkt_count, 1);

        // Randomized traffic with sparse sequence, TLAST, pad and clear faults
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(3) != 0);
            seq = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : m_bidx;
            l   = (m_bidx == PKT_LEN - 1);
            if ($urandom_range(11) == 0) l = !l;
            c   = ($urandom_range(59) == 0);
            d   = '0;
            d[DATA_W-1 -: SEQ_W] = SEQ_W'(seq);
            if ($urandom_range(19) == 0) d[$urandom_range(DATA_W-SEQ_W-1)] = 1'b1;
            tick(v, d, l, c, hs);
        end
        repeat (4) tick(1'b0, '0, 1'b0, 1'b0, hs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_seq_checker.md
# axis_seq_checker

Synthesizable AXI4-Stream sink that replaces the slave VIP's checking role in hardware. It generates a parametrised oscillating TREADY pattern and consumes fixed-length packets. Each beat is checked for an incrementing sequence number and for TLAST on the correct beat, and errors are counted for readout. It sits on the downstream end of the `chip` stream path, clocked by `aclk` alongside the master source.

## Interface
Parameters:
- DATA_W, 64, tdata width in bits; multiple of 8, ≥ SEQ_W.
- SEQ_W, 8, width of the sequence field held in tdata[DATA_W-1 -: SEQ_W].
- PKT_LEN, 8, beats per packet, ≥ 1.
- READY_LOW, 2, cycles TREADY is low per period; 0 means TREADY is held high while enabled.
- READY_HIGH, 6, cycles TREADY is high per period, ≥ 1.
- CNT_W, 16, width of the saturating counters.

Ports:
- aclk  in  1  clock; the only clock domain.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready; registered output.
- s_axis_tdata  in  DATA_W  stream data.
- s_axis_tlast  in  1  end of packet.
- enable  in  1  gates the TREADY generator.
- clear  in  1  synchronous clear of counters and beat index.
- pkt_count  out  CNT_W  saturating count of completed packets.
- err_count  out  CNT_W  saturating count of error events.
- seq_err  out  1  one-cycle pulse on a sequence or pad mismatch.
- last_err  out  1  one-cycle pulse on a misplaced or missing TLAST.
- pkt_done  out  1  one-cycle pulse when a packet closes without error.

## Operation
- A handshake occurs on a cycle where `s_axis_tvalid && s_axis_tready`. Only handshake cycles are checked.
- TREADY generator:
  - States are LOW and HIGH, with a phase counter.
  - After reset the generator is in LOW: TREADY is 0 for READY_LOW cycles, then 1 for READY_HIGH cycles, then repeats.
  - When `enable` is 0, TREADY is 0 and the phase is frozen.
  - The generator is independent of tvalid.
- Checker FSM:
  - States are IDLE and IN_PKT, with beat index `bidx` in 0..PKT_LEN-1.
  - IDLE goes to IN_PKT on the first handshake. A beat that ends the packet returns the FSM to IDLE with `bidx` at 0.
- Sequence check: the expected field is `bidx` mod 2^SEQ_W. A mismatch raises `seq_err`.
- TLAST checks:
  - TLAST with `bidx` < PKT_LEN-1 (early last): raise `last_err`; the packet ends and `bidx` resets to 0.
  - No TLAST with `bidx` = PKT_LEN-1 (missing last): raise `last_err`; `bidx` wraps to 0 and the packet is treated as closed.
- `pkt_done` pulses only when a packet closes correctly and no error occurred in any beat of that packet. The FSM keeps a sticky per-packet error flag for this.
- `pkt_count` increments on every packet close, good or bad.
- `err_count` adds `seq_err` + `last_err` on each cycle, so a beat with both errors adds 2. It saturates at 2^CNT_W-1, and `pkt_count` saturates the same way.
- `clear` has priority:
  - It zeroes both counters, `bidx`, and the sticky flag, and forces the FSM to IDLE.
  - A handshake in the same cycle is consumed but not checked.
  - The TREADY phase is not affected.

## Timing
- Reset values: `s_axis_tready`=0, `pkt_count`=0, `err_count`=0, all pulses 0, FSM in IDLE, `bidx`=0, generator in LOW with phase 0.
- If READY_LOW=0, TREADY rises on the first cycle after reset release with `enable`=1.
- Check latency is 1 cycle: error and done pulses, and the counter updates, appear in the cycle after the handshake edge.
- A reset mid-packet discards all state. The first beat after reset is expected to carry sequence 0.
- Back-to-back handshakes are checked at full rate with no bubbles.

## Configuration
- Macro: `AXIS_SEQ_CHECKER_PAD_CHECK_EN`.
- Defined: all tdata bits outside the sequence field must be zero; any nonzero bit raises `seq_err`.
- Undefined: the pad bits are ignored and only the sequence field is compared.

## Structure
- Package `axis_seq_checker_pkg` holds:
  - the checker state enum (IDLE, IN_PKT);
  - the ready-generator state enum (LOW, HIGH);
  - a function returning the saturating increment.
- Sub-module `axis_ready_gen` holds the TREADY oscillator. Its parameters are READY_LOW and READY_HIGH; its ports are `aclk`, `aresetn`, `enable`, `tready`.

## Test plan
- Defaults, tvalid always high, 8 beats with sequence 0..7 and TLAST on beat 7 → `pkt_done` pulses once, `pkt_count`=1, `err_count`=0, TREADY pattern 0,0,1,1,1,1,1,1 repeating.
- Beat 3 carries sequence 5 → `seq_err` on one cycle; `err_count`=1; no `pkt_done`; `pkt_count`=1.
- TLAST on beat 4, then a new packet 0..7 → `last_err` once, then `pkt_done` once; `pkt_count`=2, `err_count`=1.
- Beat 2 carries the wrong sequence and TLAST together → `seq_err` and `last_err` in the same cycle; `err_count`=2.
- CNT_W=2 with 5 bad beats → `err_count` saturates at 3. Then `clear` is asserted during a handshake → counters 0 and that beat is not checked.
- With the macro defined, beat 0 carries tdata=64'h00_00000000000001 → `seq_err`. With the macro undefined, the same stimulus gives no error.
